// File: rtl/int_sched_if.sv
// Processor-side bus of the interrupt scheduler: config writes plus the
// req/ack/done interrupt handshake.
interface int_sched_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        int_ack;
    logic        int_done;
    logic        int_req;
    logic [1:0]  int_id;

    // Processor side
    modport master (
        output cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
        input  int_req, int_id
    );

    // Scheduler side
    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
        output int_req, int_id
    );
endinterface

// File: rtl/int_sched.sv
// Interrupt scheduler: two interval timers, event latching into pending and
// overrun bits, mask + fixed lowest-index priority, and a single outstanding
// req/ack/done handshake towards the processor. Also emits the controller
// poll strobe from timer 0.
module int_sched #(
    parameter int unsigned TIMER_W       = 31,
    parameter int unsigned T0_RST_PERIOD = 80,
    parameter int unsigned T1_RST_PERIOD = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_src_evt,
    int_sched_if.slave  bus,
    output logic [3:0]  o_pending,
    output logic [3:0]  o_overrun,
    output logic        o_ctrl_poll
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [1:0]         r_int_id;
    logic [3:0]         r_pending;
    logic [3:0]         r_overrun;
    logic [3:0]         r_mask;
    logic               r_gie;
    logic               r_ctrl_poll;
    logic [TIMER_W-1:0] r_period [2];
    logic [TIMER_W-1:0] r_cnt    [2];

    logic [1:0]         w_per_we;
    logic [1:0]         w_tick;
    logic [3:0]         w_ev;
    logic               w_w1c;
    logic               w_ack_fire;
    logic               w_done_fire;
    logic [3:0]         w_pend_clr;
    logic [3:0]         w_ovr_clr;
    logic [3:0]         w_elig;
    logic               w_any;
    logic [1:0]         w_winner;
    logic               w_unused_wdata;

    // Upper write-data bits only matter for some registers.
    assign w_unused_wdata = ^bus.cfg_wdata;

    // Decode config writes and timer ticks; a period write suppresses that cycle's tick.
    always_comb begin
        w_per_we[0] = bus.cfg_we && (bus.cfg_addr == 2'd1);
        w_per_we[1] = bus.cfg_we && (bus.cfg_addr == 2'd2);
        w_w1c       = bus.cfg_we && (bus.cfg_addr == 2'd3);
        for (int j = 0; j < 2; j++) begin
            w_tick[j] = (r_period[j] != '0) && (r_cnt[j] == r_period[j]) && !w_per_we[j];
        end
        w_ev = {w_tick[1], w_tick[0], i_src_evt};
    end

    // Timer counters: wrap to 0 after reaching the period, held at 0 when disabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_period[0] <= TIMER_W'(T0_RST_PERIOD);
            r_period[1] <= TIMER_W'(T1_RST_PERIOD);
            r_cnt[0]    <= '0;
            r_cnt[1]    <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (w_per_we[j]) begin
                    r_period[j] <= bus.cfg_wdata[TIMER_W-1:0];
                    r_cnt[j]    <= '0;
                end else if ((r_period[j] == '0) || (r_cnt[j] == r_period[j])) begin
                    r_cnt[j] <= '0;
                end else begin
                    r_cnt[j] <= r_cnt[j] + TIMER_W'(1);
                end
            end
        end
    end

    // Clear sources for pending/overrun: accepted request and W1C writes.
    always_comb begin
        w_ack_fire  = (r_state == StReq) && bus.int_ack;
        w_done_fire = (r_state == StService) && bus.int_done;
        w_pend_clr  = (w_ack_fire ? (4'b0001 << r_int_id) : 4'b0000)
                    | (w_w1c ? bus.cfg_wdata[3:0] : 4'b0000);
        w_ovr_clr   = w_w1c ? bus.cfg_wdata[7:4] : 4'b0000;
    end

    // Pending/overrun latching; a new event always beats a same-edge clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= 4'b0000;
            r_overrun <= 4'b0000;
        end else begin
            r_overrun <= (r_overrun & ~w_ovr_clr) | (w_ev & r_pending);
            r_pending <= (r_pending & ~w_pend_clr) | w_ev;
        end
    end

    // Mask and global enable register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask <= 4'b1111;
            r_gie  <= 1'b1;
        end else if (bus.cfg_we && (bus.cfg_addr == 2'd0)) begin
            r_mask <= bus.cfg_wdata[3:0];
            r_gie  <= bus.cfg_wdata[4];
        end
    end

    // Controller poll strobe is a registered copy of the timer 0 tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ctrl_poll <= 1'b0;
        end else begin
            r_ctrl_poll <= w_tick[0];
        end
    end

    // Fixed-priority arbiter: lowest eligible index wins.
    always_comb begin
        w_elig   = r_pending & r_mask & {4{r_gie}};
        w_any    = |w_elig;
        w_winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = 2'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; ack takes precedence over done while requesting.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_any) w_state_next = StReq;
            StReq:     if (w_ack_fire) w_state_next = StService;
            StService: if (w_done_fire) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Request ID is captured on leaving IDLE and frozen until the next grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_int_id <= 2'd0;
        end else if ((r_state == StIdle) && w_any) begin
            r_int_id <= w_winner;
        end
    end

    // FSM and status outputs.
    always_comb begin
        bus.int_req = (r_state == StReq);
        bus.int_id  = r_int_id;
        o_pending   = r_pending;
        o_overrun   = r_overrun;
        o_ctrl_poll = r_ctrl_poll;
    end

endmodule

// File: tb/tb_int_sched.sv
// Self-checking bench for int_sched: directed scenarios plus a randomized run,
// all compared against a behavioural model of the scheduler.
module tb_int_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] src_evt = 2'b00;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       ctrl_poll;
    int         nvec = 0;
    int         nerr = 0;

    int_sched_if ifc ();

    int_sched dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_src_evt   (src_evt),
        .bus         (ifc),
        .o_pending   (pending),
        .o_overrun   (overrun),
        .o_ctrl_poll (ctrl_poll)
    );

    always #5 clk = ~clk;

    // Behavioural model: timers as "cycles since load modulo period+1".
    logic [3:0]  m_pend, m_ovr, m_mask;
    logic        m_gie, m_poll;
    logic [1:0]  m_id;
    int          m_st;      // 0 idle, 1 requesting, 2 in handler
    int unsigned m_per [2];
    int unsigned m_age [2];

    task automatic model_edge();
        logic [3:0] ev, clr, oclr;
        logic tk [2];
        int st_n;
        logic [1:0] id_n;
        if (rst) begin
            m_pend = 0; m_ovr = 0; m_mask = 4'hF; m_gie = 1; m_poll = 0; m_id = 0; m_st = 0;
            m_per[0] = 80; m_per[1] = 0; m_age[0] = 0; m_age[1] = 0;
            return;
        end
        for (int j = 0; j < 2; j++) begin
            tk[j] = (m_per[j] != 0) && ((m_age[j] % (m_per[j] + 1)) == m_per[j])
                    && !(ifc.cfg_we && ifc.cfg_addr == 2'(j + 1));
            m_age[j]++;
        end
        ev = {tk[1], tk[0], src_evt};
        clr = 0; oclr = 0; st_n = m_st; id_n = m_id;
        if (m_st == 0) begin
            if (m_gie)
                for (int i = 3; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) begin id_n = 2'(i); st_n = 1; end
        end else if (m_st == 1) begin
            if (ifc.int_ack) begin clr[m_id] = 1'b1; st_n = 2; end
        end else if (ifc.int_done) begin
            st_n = 0;
        end
        if (ifc.cfg_we) begin
            case (ifc.cfg_addr)
                2'd0: begin m_mask = ifc.cfg_wdata[3:0]; m_gie = ifc.cfg_wdata[4]; end
                2'd1: begin m_per[0] = ifc.cfg_wdata[30:0]; m_age[0] = 0; end
                2'd2: begin m_per[1] = ifc.cfg_wdata[30:0]; m_age[1] = 0; end
                default: begin clr = clr | ifc.cfg_wdata[3:0]; oclr = ifc.cfg_wdata[7:4]; end
            endcase
        end
        m_ovr  = (m_ovr & ~oclr) | (ev & m_pend);
        m_pend = (m_pend & ~clr) | ev;
        m_st   = st_n;
        m_id   = id_n;
        m_poll = tk[0];
    endtask

    function automatic logic [11:0] dut_vec();
        return {ifc.int_req, ifc.int_id, pending, overrun, ctrl_poll};
    endfunction

    function automatic logic [11:0] mdl_vec();
        return {m_st == 1, m_id, m_pend, m_ovr, m_poll};
    endfunction

    // One clock: inputs are stable across posedge, outputs observed at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        src_evt = 2'b00; ifc.cfg_we = 0; ifc.cfg_addr = 0; ifc.cfg_wdata = 0;
        ifc.int_ack = 0; ifc.int_done = 0;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        ifc.cfg_we = 1; ifc.cfg_addr = addr; ifc.cfg_wdata = data;
        step();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic wait_req(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            if (ifc.int_req) begin ok = 1; return; end
            step();
        end
        ok = ifc.int_req;
    endtask

    task automatic ack_and_done();
        ifc.int_ack = 1; step(); ifc.int_ack = 0;
        ifc.int_done = 1; step(); ifc.int_done = 0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if (dut_vec() !== 12'h000) begin
            nerr++; $display("FAIL reset_outputs got %h want %h", dut_vec(), 12'h000);
        end
        nvec++;
        if (dut_vec() !== mdl_vec()) begin
            nerr++; $display("FAIL reset_model got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_timer0_default();
        do_reset();
        for (int n = 1; n <= 200; n++) begin
            step();
            nvec++;
            if (ctrl_poll !== ((n == 81) || (n == 162))) begin
                nerr++; $display("FAIL t0_poll cycle %0d got %b want %b", n, ctrl_poll,
                                 (n == 81) || (n == 162));
            end
            nvec++;
            if (dut_vec() !== mdl_vec()) begin
                nerr++; $display("FAIL t0_model cycle %0d got %h want %h", n, dut_vec(), mdl_vec());
            end
            if (n == 82) begin
                nvec++;
                if ({ifc.int_req, ifc.int_id} !== 3'b110) begin
                    nerr++; $display("FAIL t0_req got req=%b id=%0d want req=1 id=2",
                                     ifc.int_req, ifc.int_id);
                end
            end
        end
    endtask

    task automatic test_two_sources();
        bit ok;
        do_reset();
        cfg_write(2'd1, 32'd0);
        src_evt = 2'b11; step(); src_evt = 2'b00;
        wait_req(10, ok);
        nvec++;
        if (!ok || ifc.int_id !== 2'd0) begin
            nerr++; $display("FAIL two_src_first got req=%b id=%0d want req=1 id=0", ok, ifc.int_id);
        end
        ack_and_done();
        wait_req(10, ok);
        nvec++;
        if (!ok || ifc.int_id !== 2'd1) begin
            nerr++; $display("FAIL two_src_second got req=%b id=%0d want req=1 id=1", ok, ifc.int_id);
        end
        ack_and_done();
        step(); step();
        nvec++;
        if (pending !== 4'b0000 || dut_vec() !== mdl_vec()) begin
            nerr++; $display("FAIL two_src_drain got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset();
        cfg_write(2'd1, 32'd0);
        src_evt = 2'b01; step(); src_evt = 2'b00; step();
        src_evt = 2'b01; step(); src_evt = 2'b00;
        wait_req(10, ok);
        nvec++;
        if (!ok || overrun !== 4'b0001 || ifc.int_id !== 2'd0) begin
            nerr++; $display("FAIL overrun_set got req=%b ovr=%b id=%0d want req=1 ovr=0001 id=0",
                             ok, overrun, ifc.int_id);
        end
        ack_and_done();
        for (int i = 0; i < 5; i++) step();
        nvec++;
        if (ifc.int_req !== 1'b0 || pending !== 4'b0000) begin
            nerr++; $display("FAIL overrun_single got req=%b pend=%b want req=0 pend=0000",
                             ifc.int_req, pending);
        end
        cfg_write(2'd3, 32'h10);
        nvec++;
        if (overrun !== 4'b0000) begin
            nerr++; $display("FAIL overrun_w1c got %b want 0000", overrun);
        end
    endtask

    task automatic test_mask();
        bit ok;
        do_reset();
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd0, 32'h1E);
        src_evt = 2'b01; step(); src_evt = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step();
            nvec++;
            if (ifc.int_req !== 1'b0 || pending[0] !== 1'b1) begin
                nerr++; $display("FAIL mask_hold got req=%b pend0=%b want req=0 pend0=1",
                                 ifc.int_req, pending[0]);
            end
        end
        cfg_write(2'd0, 32'h1F);
        wait_req(5, ok);
        nvec++;
        if (!ok || ifc.int_id !== 2'd0) begin
            nerr++; $display("FAIL mask_release got req=%b id=%0d want req=1 id=0", ok, ifc.int_id);
        end
        ack_and_done();
        nvec++;
        if (dut_vec() !== mdl_vec()) begin
            nerr++; $display("FAIL mask_model got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_no_nesting();
        bit ok;
        do_reset();
        cfg_write(2'd1, 32'd0);
        src_evt = 2'b01; step(); src_evt = 2'b00;
        wait_req(10, ok);
        ifc.int_ack = 1; step(); ifc.int_ack = 0;
        src_evt = 2'b10; step(); src_evt = 2'b00;
        for (int i = 0; i < 50; i++) begin
            step();
            nvec++;
            if (ifc.int_req !== 1'b0) begin
                nerr++; $display("FAIL nest_block cycle %0d got req=%b want 0", i, ifc.int_req);
            end
        end
        ifc.int_done = 1; step(); ifc.int_done = 0;
        nvec++;
        if (ifc.int_req !== 1'b0) begin
            nerr++; $display("FAIL nest_early got req=%b want 0", ifc.int_req);
        end
        step();
        nvec++;
        if ({ifc.int_req, ifc.int_id} !== 3'b101) begin
            nerr++; $display("FAIL nest_resume got req=%b id=%0d want req=1 id=1",
                             ifc.int_req, ifc.int_id);
        end
        ack_and_done();
    endtask

    task automatic test_timer1_and_reset();
        bit ok;
        bit prev;
        int last_rise;
        int rises;
        do_reset();
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd2, 32'd5);
        prev = 0; last_rise = -1; rises = 0;
        ifc.int_done = 1;
        for (int n = 0; n < 60; n++) begin
            ifc.int_ack = ifc.int_req;
            step();
            nvec++;
            if (dut_vec() !== mdl_vec()) begin
                nerr++; $display("FAIL t1_model cycle %0d got %h want %h", n, dut_vec(), mdl_vec());
            end
            if (ifc.int_req && !prev) begin
                rises++;
                nvec++;
                if (ifc.int_id !== 2'd3 || (last_rise >= 0 && n - last_rise != 6)) begin
                    nerr++; $display("FAIL t1_period got id=%0d gap=%0d want id=3 gap=6",
                                     ifc.int_id, n - last_rise);
                end
                last_rise = n;
            end
            prev = ifc.int_req;
        end
        nvec++;
        if (rises < 9) begin
            nerr++; $display("FAIL t1_count got %0d want >=9", rises);
        end
        idle_inputs();
        wait_req(10, ok);
        rst = 1; step(); rst = 0;
        nvec++;
        if (!ok || ifc.int_req !== 1'b0 || pending !== 4'b0000) begin
            nerr++; $display("FAIL mid_reset got seen=%b req=%b pend=%b want seen=1 req=0 pend=0000",
                             ok, ifc.int_req, pending);
        end
        for (int n = 0; n < 30; n++) begin
            step();
            nvec++;
            if (ifc.int_req !== 1'b0 || dut_vec() !== mdl_vec()) begin
                nerr++; $display("FAIL post_reset cycle %0d got %h want %h", n, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] a;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            src_evt      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            ifc.int_ack  = $urandom_range(0, 1) == 0;
            ifc.int_done = $urandom_range(0, 2) == 0;
            ifc.cfg_we   = $urandom_range(0, 19) == 0;
            a            = 2'($urandom);
            ifc.cfg_addr = a;
            if (a == 2'd1 || a == 2'd2) ifc.cfg_wdata = $urandom_range(0, 12);
            else if (a == 2'd0) ifc.cfg_wdata = {27'd0, ($urandom_range(0, 4) != 0), 4'($urandom)};
            else ifc.cfg_wdata = $urandom & 32'hFF;
            step();
            nvec++;
            if (dut_vec() !== mdl_vec()) begin
                nerr++; $display("FAIL random cycle %0d got %h want %h", n, dut_vec(), mdl_vec());
            end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_timer0_default();
        test_two_sources();
        test_overrun();
        test_mask();
        test_no_nesting();
        test_timer1_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
